// File: rtl/webp_mb_sequencer.sv
// Macroblock sequencer: walks the mb_w x mb_h raster, reads one word set per MB,
// launches the decimation engine, carries boundary context and writes one result per MB.
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH   | waiting for every input FIFO to be non-empty
//   READ    | one read strobe on all channels
//   LAUNCH  | engine start pulse
//   RUN     | waiting for engine completion
//   PUSH    | writing the result strobe, held off by out_full
//   ADVANCE | take the next context and step the raster position
//   FINISH  | frame-complete pulse
module webp_mb_sequencer #(
   parameter int N_IN      = 3,
   parameter int MB_W_BITS = 10,
   parameter int MB_H_BITS = 10,
   parameter int CTX_W     = 568
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [MB_W_BITS-1:0]         mb_w,
   input  logic [MB_H_BITS-1:0]         mb_h,
   input  logic [CTX_W-1:0]             ctx_init,
   input  logic [N_IN-1:0]              in_empty,
   output logic [N_IN-1:0]              in_rd,
   output logic                         eng_start,
   input  logic                         eng_done,
   input  logic [CTX_W-1:0]             ctx_next,
   input  logic                         out_full,
   output logic                         out_wr,
   output logic [CTX_W-1:0]             ctx,
   output logic [MB_W_BITS-1:0]         mb_x,
   output logic [MB_H_BITS-1:0]         mb_y,
   output logic [MB_W_BITS+MB_H_BITS-1:0] mb_cnt,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);

   localparam int CNT_W = MB_W_BITS + MB_H_BITS;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_READ, S_LAUNCH, S_RUN, S_PUSH, S_ADVANCE, S_FINISH
   } state_t;

   state_t                state, state_nxt;
   logic [MB_W_BITS-1:0]  w_q;
   logic [MB_H_BITS-1:0]  h_q;
   logic                  last_col, last_row, zero_dim;

   assign last_col = (mb_x == w_q - MB_W_BITS'(1));
   assign last_row = (mb_y == h_q - MB_H_BITS'(1));
   assign zero_dim = (mb_w == '0) || (mb_h == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_rd     = '0;
      eng_start = 1'b0;
      out_wr    = 1'b0;
      busy      = (state != S_IDLE);
      done      = (state == S_FINISH);
      case (state)
         S_IDLE:    if (start) state_nxt = zero_dim ? S_FINISH : S_FETCH;
         S_FETCH:   if (in_empty == '0) state_nxt = S_READ;
         S_READ: begin
            in_rd     = '1;
            state_nxt = S_LAUNCH;
         end
         S_LAUNCH: begin
            eng_start = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN:     if (eng_done) state_nxt = S_PUSH;
         S_PUSH: begin
            out_wr = !out_full;
            if (!out_full) state_nxt = (last_col && last_row) ? S_FINISH : S_ADVANCE;
         end
         S_ADVANCE: state_nxt = S_FETCH;
         S_FINISH:  state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      // abort overrides every strobe and transition outside IDLE
      if (abort && state != S_IDLE) begin
         state_nxt = S_IDLE;
         in_rd     = '0;
         eng_start = 1'b0;
         out_wr    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_q    <= '0;
         h_q    <= '0;
         ctx    <= '0;
         mb_x   <= '0;
         mb_y   <= '0;
         mb_cnt <= '0;
         err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               w_q    <= mb_w;
               h_q    <= mb_h;
               ctx    <= ctx_init;
               mb_x   <= '0;
               mb_y   <= '0;
               mb_cnt <= '0;
               err    <= zero_dim;
            end
            S_PUSH: if (out_wr) mb_cnt <= mb_cnt + CNT_W'(1);
            S_ADVANCE: if (!abort) begin
               ctx <= ctx_next;
               if (last_col) begin
                  mb_x <= '0;
                  mb_y <= mb_y + MB_H_BITS'(1);
               end else begin
                  mb_x <= mb_x + MB_W_BITS'(1);
               end
            end
            default: ;
         endcase
         // a completion pulse outside RUN means the engine and sequencer disagree
         if (state != S_IDLE && state != S_RUN && eng_done) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_webp_mb_sequencer.sv
// Bench for webp_mb_sequencer: builds a per-cycle timeline of stimulus and expected
// strobes from the frame timing rules, then replays it against the DUT.
module tb_webp_mb_sequencer;

   localparam int N_IN = 3;
   localparam int WB   = 4;
   localparam int HB   = 4;
   localparam int CW   = 32;
   localparam int MAXC = 512;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, abort, eng_done, out_full;
   logic [WB-1:0]     mb_w, mb_x;
   logic [HB-1:0]     mb_h, mb_y;
   logic [CW-1:0]     ctx_init, ctx_next, ctx;
   logic [N_IN-1:0]   in_empty, in_rd;
   logic              eng_start, out_wr, busy, done, err;
   logic [WB+HB-1:0]  mb_cnt;

   webp_mb_sequencer #(.N_IN(N_IN), .MB_W_BITS(WB), .MB_H_BITS(HB), .CTX_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mb_w(mb_w), .mb_h(mb_h),
      .ctx_init(ctx_init), .in_empty(in_empty), .in_rd(in_rd), .eng_start(eng_start),
      .eng_done(eng_done), .ctx_next(ctx_next), .out_full(out_full), .out_wr(out_wr),
      .ctx(ctx), .mb_x(mb_x), .mb_y(mb_y), .mb_cnt(mb_cnt), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // per-MB stall plan: empty cycles in FETCH, wait cycles in RUN, full cycles in PUSH
   int st_e[16], st_r[16], st_f[16];

   logic [N_IN-1:0] s_empty[MAXC];
   logic            s_edone[MAXC], s_full[MAXC], s_start[MAXC];
   logic [CW-1:0]   s_cn[MAXC];
   logic            e_rd[MAXC], e_es[MAXC], e_wr[MAXC], e_done[MAXC];
   logic [WB+HB+CW-1:0] e_wq[$];

   task automatic clear_stalls();
      for (int k = 0; k < 16; k++) begin
         st_e[k] = 0; st_r[k] = 0; st_f[k] = 0;
      end
   endtask

   task automatic run_frame(input int w, input int h, input int abort_mb, input int stray_mb,
                            input int rst_mb);
      int n, t, tend, a, rs, sc, last, cnt;
      logic [CW-1:0] init, cur, nx;
      logic live, busy_e, wr_e, stop, err_e;
      n = w * h; a = -1; rs = -1; sc = -1; cnt = 0; stop = 1'b0;
      init = $urandom; cur = init;
      for (int c = 0; c < MAXC; c++) begin
         s_empty[c] = N_IN'($urandom); s_edone[c] = 1'b0; s_full[c] = 1'($urandom);
         s_start[c] = 1'b0; s_cn[c] = $urandom;
         e_rd[c] = 1'b0; e_es[c] = 1'b0; e_wr[c] = 1'b0; e_done[c] = 1'b0;
      end
      e_wq.delete();
      t = 1;
      for (int k = 0; k < n; k++) begin
         nx = $urandom;
         for (int j = 0; j < st_e[k]; j++) s_empty[t+j] = N_IN'($urandom_range(1, (1 << N_IN) - 1));
         s_empty[t+st_e[k]] = '0;
         if (k == stray_mb) begin s_edone[t] = 1'b1; sc = t; end
         t += st_e[k] + 1;
         e_rd[t] = 1'b1;
         e_es[t+1] = 1'b1;
         if (k == abort_mb) a = t + 2;
         s_edone[t+2+st_r[k]] = 1'b1;
         for (int c = t + 2; c <= t + 4 + st_r[k] + st_f[k]; c++) s_cn[c] = nx;
         t += 3 + st_r[k];
         for (int j = 0; j < st_f[k]; j++) s_full[t+j] = 1'b1;
         s_full[t+st_f[k]] = 1'b0;
         e_wr[t+st_f[k]] = 1'b1;
         e_wq.push_back({WB'(k % w), HB'(k / w), cur});
         if (k == rst_mb) rs = t + st_f[k];
         t += st_f[k] + 1;
         if (k < n - 1) begin cur = nx; t += 1; end
      end
      tend = t;
      e_done[tend] = 1'b1;
      last = (a >= 0) ? a : tend;
      s_start[0] = 1'b1;
      for (int c = 1; c <= last; c++) s_start[c] = 1'($urandom);
      for (int c = last + 1; c <= last + 3; c++) s_edone[c] = 1'($urandom);

      for (int c = 0; c <= last + 3 && !stop; c++) begin
         @(negedge clk);
         start = s_start[c]; abort = (c == a); eng_done = s_edone[c]; out_full = s_full[c];
         in_empty = s_empty[c]; ctx_next = s_cn[c];
         mb_w = (c == 0) ? WB'(w) : WB'($urandom);
         mb_h = (c == 0) ? HB'(h) : HB'($urandom);
         ctx_init = (c == 0) ? init : CW'($urandom);
         #1;
         live   = (a < 0) || (c < a);
         busy_e = (c >= 1) && (c <= last);
         wr_e   = live && e_wr[c];
         chk($sformatf("strobes_c%0d", c), {in_rd, eng_start, out_wr, busy, done},
             {{N_IN{live && e_rd[c]}}, live && e_es[c], wr_e, busy_e, live && e_done[c]});
         if (wr_e) begin
            chk($sformatf("mb_at_wr%0d", cnt), {mb_cnt, mb_x, mb_y, ctx}, {(WB+HB)'(cnt), e_wq.pop_front()});
            cnt++;
         end
         if (c == rs) begin
            rst = 1'b1;
            #1;
            chk("rst_mid_push", {in_rd, eng_start, out_wr, busy, done, err, mb_x, mb_y, mb_cnt, ctx}, 64'd0);
            stop = 1'b1;
         end
      end
      start = 1'b0; abort = 1'b0; eng_done = 1'b0;
      if (stop) begin
         @(negedge clk);
         rst = 1'b0;
      end else begin
         err_e = (n == 0) || (sc >= 0 && (a < 0 || sc < a));
         chk("mb_cnt_end", mb_cnt, cnt);
         chk("err_end", err, err_e);
         if (a < 0 && n > 0) chk("pos_end", {mb_x, mb_y}, {WB'(w - 1), HB'(h - 1)});
      end
   endtask

   task automatic rand_frame();
      int w, h, n, ab, sm;
      w = $urandom_range(1, 3); h = $urandom_range(1, 3); n = w * h;
      for (int k = 0; k < n; k++) begin
         st_e[k] = $urandom_range(0, 2); st_r[k] = $urandom_range(0, 2); st_f[k] = $urandom_range(0, 2);
      end
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      sm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame(w, h, ab, sm, -1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; eng_done = 1'b0; out_full = 1'b0;
      mb_w = '0; mb_h = '0; ctx_init = '0; ctx_next = '0; in_empty = '0;
      @(negedge clk);
      #1;
      chk("reset", {in_rd, eng_start, out_wr, busy, done, err, mb_x, mb_y, mb_cnt, ctx}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      clear_stalls(); run_frame(2, 2, -1, -1, -1);
      clear_stalls(); st_e[0] = 3; run_frame(1, 1, -1, -1, -1);
      clear_stalls(); st_f[1] = 4; run_frame(3, 1, -1, -1, -1);
      clear_stalls(); run_frame(4, 4, 2, -1, -1);
      clear_stalls(); run_frame(4, 4, -1, -1, -1);
      clear_stalls(); run_frame(0, 2, -1, -1, -1);
      clear_stalls(); run_frame(3, 0, -1, -1, -1);
      clear_stalls(); run_frame(2, 2, -1, 1, -1);
      clear_stalls(); run_frame(2, 2, -1, -1, 1);
      clear_stalls(); run_frame(2, 1, -1, -1, -1);
      for (int i = 0; i < 14; i++) rand_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
